// File: rtl/obj_affine_pipe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : obj_affine_pkg                                                |
// | Purpose  : Shared widths, affine parameter / stage payload types and a   |
// |            size helper for the OBJ affine texel-coordinate pipeline.     |
// | Ports    : none (package)                                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package obj_affine_pkg;

  localparam int c_COORD_W = 9;
  localparam int c_TEX_W   = 7;
  localparam int c_FRAC_W  = 8;
  localparam int c_PARAM_W = 16;
  localparam int c_TAG_W   = 8;

  // Screen-minus-centre deltas need two extra bits: the centre can sit up to
  // 2^TEX_W right of a bounding-box edge that is already at the coordinate limit.
  localparam int c_DELTA_W = c_COORD_W + 2;
  // Two full-precision products summed: one more bit than a single product.
  localparam int c_ACC_W   = c_PARAM_W + c_COORD_W + 3;

  typedef logic signed [c_ACC_W-1:0] acc_t;

  typedef struct packed {
    logic signed [c_PARAM_W-1:0] pa;
    logic signed [c_PARAM_W-1:0] pb;
    logic signed [c_PARAM_W-1:0] pc;
    logic signed [c_PARAM_W-1:0] pd;
  } affine_params_t;

  // Per-request configuration still needed after the centre/delta stage.
  typedef struct packed {
    logic [c_TEX_W:0]   hsize;
    logic [c_TEX_W:0]   vsize;
    logic               wrap_en;
    logic [c_TAG_W-1:0] tag;
  } pix_meta_t;

  // Payload held in the centre/delta stage register.
  typedef struct packed {
    affine_params_t              prm;
    logic signed [c_DELTA_W-1:0] dx;
    logic signed [c_DELTA_W-1:0] dy;
    pix_meta_t                   meta;
  } s1_payload_t;

  function automatic logic [c_TEX_W:0] half_size(input logic [c_TEX_W:0] size);
    return size >> 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/obj_affine_pipe_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : obj_affine_pipe_if                                            |
// | Purpose  : Request/response bundle of the affine texel pipeline.         |
// | Ports    : master drives in_valid, col/row, objx/objy, pa..pd, sizes,    |
// |            dblsize, wrap_en, tag_in, out_ready; slave drives in_ready,   |
// |            out_valid, tex_x, tex_y, transparent, tag_out.                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface obj_affine_pipe_if #(
  parameter int COORD_W = 9,
  parameter int TEX_W   = 7,
  parameter int PARAM_W = 16,
  parameter int TAG_W   = 8
);
  logic                      in_valid;
  logic                      in_ready;
  logic signed [COORD_W-1:0] col;
  logic signed [COORD_W-1:0] row;
  logic signed [COORD_W-1:0] objx;
  logic signed [COORD_W-1:0] objy;
  logic signed [PARAM_W-1:0] pa;
  logic signed [PARAM_W-1:0] pb;
  logic signed [PARAM_W-1:0] pc;
  logic signed [PARAM_W-1:0] pd;
  logic [TEX_W:0]            hsize;
  logic [TEX_W:0]            vsize;
  logic                      dblsize;
  logic                      wrap_en;
  logic [TAG_W-1:0]          tag_in;
  logic                      out_valid;
  logic                      out_ready;
  logic [TEX_W-1:0]          tex_x;
  logic [TEX_W-1:0]          tex_y;
  logic                      transparent;
  logic [TAG_W-1:0]          tag_out;

  modport master (
    output in_valid, col, row, objx, objy, pa, pb, pc, pd,
           hsize, vsize, dblsize, wrap_en, tag_in, out_ready,
    input  in_ready, out_valid, tex_x, tex_y, transparent, tag_out
  );

  modport slave (
    input  in_valid, col, row, objx, objy, pa, pb, pc, pd,
           hsize, vsize, dblsize, wrap_en, tag_in, out_ready,
    output in_ready, out_valid, tex_x, tex_y, transparent, tag_out
  );
endinterface
`default_nettype wire

// File: rtl/obj_affine_pipe_mac.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : obj_affine_mac                                                |
// | Purpose  : Signed two-product multiply-add, res = (a*x + b*y) >>> FRAC_W.|
// |            Products are registered; the add/shift is combinational on    |
// |            the registered products.                                      |
// | Ports    : clk, rst, en_i (product load), a_i/b_i coefficients,          |
// |            x_i/y_i deltas, res_o floored fixed-point result.             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module obj_affine_mac #(
  parameter int PARAM_W = 16,
  parameter int DELTA_W = 11,
  parameter int FRAC_W  = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en_i,
  input  logic signed [PARAM_W-1:0]        a_i,
  input  logic signed [PARAM_W-1:0]        b_i,
  input  logic signed [DELTA_W-1:0]        x_i,
  input  logic signed [DELTA_W-1:0]        y_i,
  output logic signed [PARAM_W+DELTA_W:0]  res_o
);
  localparam int c_PROD_W = PARAM_W + DELTA_W;
  localparam int c_SUM_W  = PARAM_W + DELTA_W + 1;

  logic signed [c_PROD_W-1:0] prod_a_d, prod_b_d;
  logic signed [c_PROD_W-1:0] prod_a_q, prod_b_q;
  logic signed [c_SUM_W-1:0]  w_sum;

  // Operands are sign-extended to the full product width first so the
  // multiply is exact for every combination, including -2^(PARAM_W-1).
  assign prod_a_d = c_PROD_W'(a_i) * c_PROD_W'(x_i);
  assign prod_b_d = c_PROD_W'(b_i) * c_PROD_W'(y_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_a_q <= '0;
      prod_b_q <= '0;
    end else if (en_i) begin
      prod_a_q <= prod_a_d;
      prod_b_q <= prod_b_d;
    end
  end

  assign w_sum = c_SUM_W'(prod_a_q) + c_SUM_W'(prod_b_q);
  // Arithmetic shift floors toward minus infinity, not toward zero.
  assign res_o = w_sum >>> FRAC_W;

endmodule
`default_nettype wire

// File: rtl/obj_affine_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : obj_affine_pipe                                               |
// | Purpose  : 3-stage valid/ready affine texel-coordinate generator. Maps a |
// |            screen pixel inside an affine sprite's bounding box to a      |
// |            texel, flagging or wrapping out-of-sprite results.            |
// |            S1 centre/delta, S2 products, S3 accumulate/resolve.          |
// | Ports    : clk, rst (sync, active high); bus (slave modport) carrying    |
// |            the request fields/handshake and result fields/handshake.    |
// |            Stage payload types come from obj_affine_pkg, so parameter    |
// |            overrides must match the package widths.                      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module obj_affine_pipe
  import obj_affine_pkg::*;
#(
  parameter int COORD_W = c_COORD_W,
  parameter int TEX_W   = c_TEX_W,
  parameter int FRAC_W  = c_FRAC_W,
  parameter int PARAM_W = c_PARAM_W,
  parameter int TAG_W   = c_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  obj_affine_pipe_if.slave bus
);
  localparam int DELTA_W = COORD_W + 2;

  // Stall chain: a stage loads when it is empty or its content moves on.
  logic w_load_s1, w_load_s2, w_load_s3;
  logic s1_valid_q, s2_valid_q, out_valid_q;

  assign w_load_s3 = !out_valid_q || bus.out_ready;
  assign w_load_s2 = !s2_valid_q  || w_load_s3;
  assign w_load_s1 = !s1_valid_q  || w_load_s2;
  assign bus.in_ready = w_load_s1;

  // ---------------- S1: centre and delta ----------------
  logic [TEX_W:0]            w_off_x, w_off_y;
  logic signed [DELTA_W-1:0] w_cx, w_cy;
  s1_payload_t               s1_d, s1_q;

  assign w_off_x = bus.dblsize ? bus.hsize : half_size(bus.hsize);
  assign w_off_y = bus.dblsize ? bus.vsize : half_size(bus.vsize);
  assign w_cx    = DELTA_W'(bus.objx) + $signed(DELTA_W'(w_off_x));
  assign w_cy    = DELTA_W'(bus.objy) + $signed(DELTA_W'(w_off_y));

  always_comb begin
    s1_d              = '0;
    s1_d.prm.pa       = bus.pa;
    s1_d.prm.pb       = bus.pb;
    s1_d.prm.pc       = bus.pc;
    s1_d.prm.pd       = bus.pd;
    s1_d.dx           = DELTA_W'(bus.col) - w_cx;
    s1_d.dy           = DELTA_W'(bus.row) - w_cy;
    s1_d.meta.hsize   = bus.hsize;
    s1_d.meta.vsize   = bus.vsize;
    s1_d.meta.wrap_en = bus.wrap_en;
    s1_d.meta.tag     = bus.tag_in;
  end

  // ---------------- S2: products (registered inside the MACs) ----------------
  logic      w_adv_s2;
  pix_meta_t meta2_q;
  acc_t      w_sx, w_sy;

  assign w_adv_s2 = w_load_s2 && s1_valid_q;

  obj_affine_mac #(.PARAM_W(PARAM_W), .DELTA_W(DELTA_W), .FRAC_W(FRAC_W)) u_mac_x (
    .clk   (clk),
    .rst   (rst),
    .en_i  (w_adv_s2),
    .a_i   (s1_q.prm.pa),
    .b_i   (s1_q.prm.pb),
    .x_i   (s1_q.dx),
    .y_i   (s1_q.dy),
    .res_o (w_sx)
  );

  obj_affine_mac #(.PARAM_W(PARAM_W), .DELTA_W(DELTA_W), .FRAC_W(FRAC_W)) u_mac_y (
    .clk   (clk),
    .rst   (rst),
    .en_i  (w_adv_s2),
    .a_i   (s1_q.prm.pc),
    .b_i   (s1_q.prm.pd),
    .x_i   (s1_q.dx),
    .y_i   (s1_q.dy),
    .res_o (w_sy)
  );

  // ---------------- S3: re-centre and resolve ----------------
  acc_t             w_tx, w_ty, w_hs, w_vs;
  logic             w_oob;
  logic [TEX_W-1:0] w_mask_x, w_mask_y;
  logic [TEX_W-1:0] tex_x_d, tex_y_d, tex_x_q, tex_y_q;
  logic             transp_d, transp_q;
  logic [TAG_W-1:0] tag_q;

  assign w_hs  = acc_t'(meta2_q.hsize);
  assign w_vs  = acc_t'(meta2_q.vsize);
  assign w_tx  = w_sx + acc_t'(half_size(meta2_q.hsize));
  assign w_ty  = w_sy + acc_t'(half_size(meta2_q.vsize));
  assign w_oob = (w_tx < 0) || (w_tx >= w_hs) || (w_ty < 0) || (w_ty >= w_vs);

  // Sizes are powers of two, so size-1 is the modulo mask for wrapping.
  assign w_mask_x = TEX_W'(meta2_q.hsize - (TEX_W+1)'(1));
  assign w_mask_y = TEX_W'(meta2_q.vsize - (TEX_W+1)'(1));

  always_comb begin
    tex_x_d  = w_tx[TEX_W-1:0];
    tex_y_d  = w_ty[TEX_W-1:0];
    transp_d = w_oob;
    if (meta2_q.wrap_en) begin
      tex_x_d  = w_tx[TEX_W-1:0] & w_mask_x;
      tex_y_d  = w_ty[TEX_W-1:0] & w_mask_y;
      transp_d = 1'b0;
    end
  end

  // ---------------- stage registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      s1_q        <= '0;
      meta2_q     <= '0;
      tex_x_q     <= '0;
      tex_y_q     <= '0;
      transp_q    <= 1'b0;
      tag_q       <= '0;
    end else begin
      if (w_load_s1) begin
        s1_valid_q <= bus.in_valid;
        if (bus.in_valid) s1_q <= s1_d;
      end
      if (w_load_s2) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) meta2_q <= s1_q.meta;
      end
      // Outputs only change when S3 loads, which holds them while stalled.
      if (w_load_s3) begin
        out_valid_q <= s2_valid_q;
        if (s2_valid_q) begin
          tex_x_q  <= tex_x_d;
          tex_y_q  <= tex_y_d;
          transp_q <= transp_d;
          tag_q    <= TAG_W'(meta2_q.tag);
        end
      end
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.tex_x       = tex_x_q;
  assign bus.tex_y       = tex_y_q;
  assign bus.transparent = transp_q;
  assign bus.tag_out     = tag_q;

endmodule
`default_nettype wire

// File: tb/tb_obj_affine_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_obj_affine_pipe                                            |
// | Purpose  : Self-checking bench for obj_affine_pipe: directed cases,      |
// |            backpressure, mid-stream reset and randomized traffic checked |
// |            against an integer reference model with a scoreboard.         |
// | Ports    : none                                                          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_obj_affine_pipe;
  localparam int FRAC_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  obj_affine_pipe_if #(.COORD_W(9), .TEX_W(7), .PARAM_W(16), .TAG_W(8)) bus_if ();

  obj_affine_pipe #(.COORD_W(9), .TEX_W(7), .FRAC_W(8), .PARAM_W(16), .TAG_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  typedef struct {
    int col, row, objx, objy, pa, pb, pc, pd, hsize, vsize, tag;
    bit dbl, wrap;
  } req_t;

  typedef struct {
    int tx, ty, tag;
    bit transp;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   emitted = 0;
  int   or_mode = 0;   // 0: always ready, 1: 1,0,0 pattern, 2: random
  exp_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint fdiv(input longint n, input longint d);
    longint q;
    q = n / d;
    if ((n % d != 0) && (n < 0)) q = q - 1;
    return q;
  endfunction

  function automatic longint pmod(input longint v, input longint m);
    return ((v % m) + m) % m;
  endfunction

  function automatic exp_t model(input req_t r);
    exp_t   e;
    longint cx, cy, dx, dy, tx, ty;
    cx = r.objx + (r.dbl ? r.hsize : r.hsize / 2);
    cy = r.objy + (r.dbl ? r.vsize : r.vsize / 2);
    dx = r.col - cx;
    dy = r.row - cy;
    tx = fdiv(longint'(r.pa) * dx + longint'(r.pb) * dy, 1 << FRAC_W) + r.hsize / 2;
    ty = fdiv(longint'(r.pc) * dx + longint'(r.pd) * dy, 1 << FRAC_W) + r.vsize / 2;
    if (r.wrap) begin
      e.transp = 1'b0;
      e.tx = int'(pmod(tx, r.hsize));
      e.ty = int'(pmod(ty, r.vsize));
    end else begin
      e.transp = (tx < 0) || (tx >= r.hsize) || (ty < 0) || (ty >= r.vsize);
      e.tx = int'(pmod(tx, 128));
      e.ty = int'(pmod(ty, 128));
    end
    e.tag = r.tag;
    return e;
  endfunction

  function automatic bit legal_size(input int s);
    return (s >= 8) && (s <= 128) && ((s & (s - 1)) == 0);
  endfunction

  // ---------------- monitor / scoreboard ----------------
  req_t        mr;
  exp_t        me;
  bit          prev_stall = 0;
  logic [6:0]  prev_tx, prev_ty;
  logic        prev_tr;
  logic [7:0]  prev_tag;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_stall = 0;
    end else begin
      check("in_ready", bus_if.in_ready, (exp_q.size() < 3) || bus_if.out_ready);
      if (prev_stall) begin
        check("hold_valid", bus_if.out_valid, 1);
        check("hold_tex_x", bus_if.tex_x, prev_tx);
        check("hold_tex_y", bus_if.tex_y, prev_ty);
        check("hold_transp", bus_if.transparent, prev_tr);
        check("hold_tag", bus_if.tag_out, prev_tag);
      end
      if (bus_if.out_valid && bus_if.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          me = exp_q.pop_front();
          check("transparent", bus_if.transparent, me.transp);
          if (!me.transp) begin
            check("tex_x", bus_if.tex_x, me.tx);
            check("tex_y", bus_if.tex_y, me.ty);
          end
          check("tag_out", bus_if.tag_out, me.tag);
        end
        emitted++;
      end
      if (bus_if.in_valid && bus_if.in_ready) begin
        mr.col = int'(bus_if.col);   mr.row = int'(bus_if.row);
        mr.objx = int'(bus_if.objx); mr.objy = int'(bus_if.objy);
        mr.pa = int'(bus_if.pa); mr.pb = int'(bus_if.pb);
        mr.pc = int'(bus_if.pc); mr.pd = int'(bus_if.pd);
        mr.hsize = int'(bus_if.hsize); mr.vsize = int'(bus_if.vsize);
        mr.dbl = bus_if.dblsize; mr.wrap = bus_if.wrap_en;
        mr.tag = int'(bus_if.tag_in);
        exp_q.push_back(model(mr));
      end
      prev_stall = bus_if.out_valid && !bus_if.out_ready;
      prev_tx = bus_if.tex_x; prev_ty = bus_if.tex_y;
      prev_tr = bus_if.transparent; prev_tag = bus_if.tag_out;
    end
  end

  // ---------------- out_ready driver ----------------
  initial begin
    int phase;
    phase = 0;
    bus_if.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (or_mode)
        1: begin
          bus_if.out_ready = (phase == 0);
          phase = (phase + 1) % 3;
        end
        2: bus_if.out_ready = 1'($urandom_range(0, 1));
        default: bus_if.out_ready = 1'b1;
      endcase
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic apply(input req_t r);
    int v;
    assert (legal_size(r.hsize) && legal_size(r.vsize)) else begin
      errors++;
      $error("FAIL size_legal hsize=%0d vsize=%0d", r.hsize, r.vsize);
    end
    v = r.col;   bus_if.col  = v[8:0];
    v = r.row;   bus_if.row  = v[8:0];
    v = r.objx;  bus_if.objx = v[8:0];
    v = r.objy;  bus_if.objy = v[8:0];
    v = r.pa;    bus_if.pa   = v[15:0];
    v = r.pb;    bus_if.pb   = v[15:0];
    v = r.pc;    bus_if.pc   = v[15:0];
    v = r.pd;    bus_if.pd   = v[15:0];
    v = r.hsize; bus_if.hsize = v[7:0];
    v = r.vsize; bus_if.vsize = v[7:0];
    v = r.tag;   bus_if.tag_in = v[7:0];
    bus_if.dblsize = r.dbl;
    bus_if.wrap_en = r.wrap;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input req_t r);
    int n;
    apply(r);
    bus_if.in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus_if.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("accept_timeout", 1, 0);
    @(posedge clk);
    #1;
    bus_if.in_valid = 1'b0;
  endtask

  // Sends one request into an empty pipe and stops at the negedge where the
  // result is presented.
  task automatic run_one(input req_t r);
    int k;
    send(r);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus_if.out_valid && k < 20);
    check("latency", k, 3);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
    #1;
  endtask

  function automatic int sign9(input int v);
    return int'(pmod(v + 256, 512)) - 256;
  endfunction

  function automatic int rand_param();
    case ($urandom_range(0, 4))
      0: return -32768;
      1: return 32767;
      2: return int'($urandom_range(0, 65535)) - 32768;
      default: return int'($urandom_range(0, 1024)) - 512;
    endcase
  endfunction

  function automatic req_t rand_req(input int tag);
    req_t r;
    int   sz[5] = '{8, 16, 32, 64, 128};
    r.hsize = sz[$urandom_range(0, 4)];
    r.vsize = sz[$urandom_range(0, 4)];
    r.objx = int'($urandom_range(0, 511)) - 256;
    r.objy = int'($urandom_range(0, 511)) - 256;
    r.dbl  = 1'($urandom_range(0, 1));
    r.wrap = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 3) != 0) begin
      r.col = sign9(r.objx + int'($urandom_range(0, 2 * r.hsize - 1)));
      r.row = sign9(r.objy + int'($urandom_range(0, 2 * r.vsize - 1)));
    end else begin
      r.col = int'($urandom_range(0, 511)) - 256;
      r.row = int'($urandom_range(0, 511)) - 256;
    end
    r.pa = rand_param(); r.pb = rand_param();
    r.pc = rand_param(); r.pd = rand_param();
    r.tag = tag & 255;
    return r;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    req_t base, r;
    int   n0;
    bus_if.in_valid = 1'b0;
    base = '{col: 110, row: 60, objx: 100, objy: 50, pa: 256, pb: 0, pc: 0, pd: 256,
             hsize: 16, vsize: 16, tag: 8'h11, dbl: 1'b0, wrap: 1'b0};
    apply(base);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", bus_if.out_valid, 0);
    check("rst_tex_x", bus_if.tex_x, 0);
    check("rst_tex_y", bus_if.tex_y, 0);
    check("rst_transp", bus_if.transparent, 0);
    check("rst_tag", bus_if.tag_out, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", bus_if.in_ready, 1);
    settle();

    // Identity
    run_one(base);
    check("id_tex_x", bus_if.tex_x, 10);
    check("id_tex_y", bus_if.tex_y, 10);
    check("id_transp", bus_if.transparent, 0);
    check("id_tag", bus_if.tag_out, 8'h11);
    settle();

    // 90 degree rotation
    r = base; r.pa = 0; r.pd = 0; r.pb = 256; r.pc = -256; r.tag = 8'h22;
    run_one(r);
    check("rot_tex_x", bus_if.tex_x, 10);
    check("rot_tex_y", bus_if.tex_y, 6);
    settle();

    // Half scale, double-size box: texel y lands at 34, outside a 16-row sprite
    r = base; r.pa = 128; r.pd = 128; r.dbl = 1'b1; r.col = 118; r.row = 118; r.tag = 8'h33;
    run_one(r);
    check("dbl_transp", bus_if.transparent, 1);
    settle();

    // Wrap versus transparent, left of the sprite
    r = base; r.col = 99; r.tag = 8'h44;
    run_one(r);
    check("left_nowrap_transp", bus_if.transparent, 1);
    settle();
    r.wrap = 1'b1;
    run_one(r);
    check("left_wrap_tex_x", bus_if.tex_x, 15);
    check("left_wrap_transp", bus_if.transparent, 0);
    settle();

    // Wrap versus transparent, right of the sprite
    r = base; r.col = 120; r.tag = 8'h55;
    run_one(r);
    check("right_nowrap_transp", bus_if.transparent, 1);
    settle();
    r.wrap = 1'b1;
    run_one(r);
    check("right_wrap_tex_x", bus_if.tex_x, 4);
    settle();

    // Extreme pa with dx=-130: (32768*130 - 1)/256 floors to 16639, tx=16647
    r = base; r.pa = -32768; r.pb = 1; r.col = -22; r.row = 57; r.wrap = 1'b1; r.tag = 8'h66;
    run_one(r);
    check("ext_tex_x", bus_if.tex_x, 7);
    check("ext_tex_y", bus_if.tex_y, 7);
    check("ext_transp", bus_if.transparent, 0);
    settle();

    // Backpressure: 8 back-to-back requests with out_ready 1,0,0,...
    or_mode = 1;
    n0 = emitted;
    for (int i = 0; i < 8; i++) begin
      r = base; r.col = 100 + 2 * i; r.tag = 8'hA0 + i;
      send(r);
    end
    drain();
    check("bp_count", emitted - n0, 8);
    or_mode = 0;
    settle();

    // Reset with two requests in flight
    r = base; r.tag = 8'h77;
    send(r);
    r.tag = 8'h78;
    send(r);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n0 = emitted;
    @(negedge clk);
    check("mid_rst_out_valid", bus_if.out_valid, 0);
    check("mid_rst_tex_x", bus_if.tex_x, 0);
    check("mid_rst_tex_y", bus_if.tex_y, 0);
    check("mid_rst_tag", bus_if.tag_out, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("mid_rst_no_stale", bus_if.out_valid, 0);
    end
    check("mid_rst_emitted", emitted - n0, 0);
    settle();

    // Randomized traffic with random backpressure and idle gaps
    or_mode = 2;
    for (int i = 0; i < 150; i++) begin
      send(rand_req(i));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) settle();
    end
    drain();
    or_mode = 0;
    repeat (3) settle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/obj_affine_pipe.md
Name: obj_affine_pipe

Overview:
- Pipelined affine (rotation/scale) texel-coordinate generator for OBJ rendering.
- Maps a screen pixel (col, row) inside an affine sprite's bounding box to a texel (tex_x, tex_y) in the sprite's source bitmap, and flags out-of-sprite pixels as transparent or wraps them.
- Sits between the OBJ line scanner and the tile/VRAM fetch stage.
- Parametrised successor of the single-cycle combinational rot/scale unit. Adds:
  - true signed math;
  - valid/ready flow control;
  - a wrap mode;
  - a pass-through tag;
  - configurable texel range.

Parameters:
- COORD_W, 9: width of signed screen/object coordinates.
- TEX_W, 7: width of texel coordinate outputs; maximum sprite dimension is 2^TEX_W.
- FRAC_W, 8: fractional bits of the affine parameters.
- PARAM_W, 16: width of the signed fixed-point affine parameters pa..pd.
- TAG_W, 8: width of the opaque sideband tag carried alongside each request.

Ports:
- clock, in, 1: system clock.
- reset, in, 1: synchronous, active-high reset.
- in_valid, in, 1: request valid.
- in_ready, out, 1: request accepted when in_valid && in_ready.
- col, in, COORD_W: screen x, signed.
- row, in, COORD_W: screen y, signed.
- objx, in, COORD_W: bounding-box left edge, signed.
- objy, in, COORD_W: bounding-box top edge, signed.
- pa, pb, pc, pd, in, PARAM_W each: signed fixed-point affine matrix entries.
- hsize, in, TEX_W+1: sprite width; must be a power of two, 8..2^TEX_W.
- vsize, in, TEX_W+1: sprite height; same rules as hsize.
- dblsize, in, 1: bounding box is 2*hsize by 2*vsize.
- wrap_en, in, 1: wrap out-of-range texels instead of flagging them transparent.
- tag_in, in, TAG_W: sideband data, returned unchanged.
- out_valid, out, 1: result valid.
- out_ready, in, 1: result consumed when out_valid && out_ready.
- tex_x, out, TEX_W: texel column.
- tex_y, out, TEX_W: texel row.
- transparent, out, 1: pixel lies outside the sprite; tex_x/tex_y are don't-care.
- tag_out, out, TAG_W: tag of the result.

Behaviour:
- Reset:
  - all stage valid bits clear;
  - out_valid=0, tex_x=0, tex_y=0, transparent=0, tag_out=0;
  - in_ready=1 in the first cycle after reset deasserts.
  - Reset asserted mid-operation discards all in-flight requests; nothing is emitted after it.
- Pipeline: 3 registered stages. Latency is 3 cycles from acceptance to out_valid, with no stalls.
  - S1 (centre/delta):
    - cx = objx + (dblsize ? hsize : hsize>>1);
    - cy = objy + (dblsize ? vsize : vsize>>1);
    - dx = col - cx and dy = row - cy, signed, COORD_W+2 bits, with no truncation.
  - S2 (multiply): pa*dx, pb*dy, pc*dx, pd*dy, each full-precision signed, PARAM_W+COORD_W+2 bits.
  - S3 (accumulate/resolve):
    - sx = (pa*dx + pb*dy) >>> FRAC_W, arithmetic shift, so the result is floored;
    - tx = sx + (hsize>>1);
    - ty is computed the same way from pc, pd and vsize.
    - If wrap_en=0: transparent = (tx<0) || (tx>=hsize) || (ty<0) || (ty>=vsize).
    - If wrap_en=1: tex_x = tx & (hsize-1), tex_y = ty & (vsize-1), and transparent=0.
    - When not transparent, tex_x = tx[TEX_W-1:0].
- Flow control: standard stall chain.
  - A stage advances when its successor is empty or is advancing.
  - in_ready = !S1.valid || S1 advancing.
  - S3 advances on out_ready || !out_valid.
  - While out_valid=1 and out_ready=0, every output is held stable.
  - Full throughput is 1 result per cycle.
  - Accept and emit in the same cycle is allowed when the pipe is full.
- Configuration (objx..wrap_en) is sampled per request and travels with it down the pipe. Mixing sprites back-to-back is legal.
- pa = 0x8000 (−128.0) and similar extremes must not overflow: accumulator width is PARAM_W+COORD_W+3.
- hsize/vsize that are not a power of two, or outside 8..2^TEX_W: behaviour undefined. The bench asserts against this.

Decomposition:
- Package obj_affine_pkg holds:
  - typedef affine_params_t (struct pa, pb, pc, pd);
  - a localparam for accumulator width;
  - a per-stage payload struct typedef.
- Sub-module obj_affine_mac: signed two-product multiply-add with arithmetic shift. Instantiated twice, once for x and once for y; its multiply stage is registered.

Test Plan:
- Identity, no wrap.
  - Stimulus: pa=pd=0x0100, pb=pc=0, hsize=vsize=16, objx=100, objy=50, dblsize=0, col=110, row=60.
  - Response after 3 cycles: tex_x=10, tex_y=10, transparent=0, tag returned.
- 90° rotation.
  - Stimulus: pa=pd=0, pb=0x0100, pc=0xFF00, same point as the identity case.
  - Response: tex_x=10, tex_y=6.
- Scale and double size.
  - Stimulus: pa=pd=0x0080, dblsize=1, hsize=vsize=16, objx=100, objy=50, col=118, row=118.
  - Response: dx=2 and dy=52 → tex_x=9, tex_y=34 → transparent=1.
- Wrap versus transparent.
  - Stimulus: identity with col=99, so tx=−1.
  - Response with wrap_en=0: transparent=1. With wrap_en=1: tex_x=15, transparent=0.
  - Stimulus: col=120.
  - Response with wrap_en=0: transparent=1. With wrap_en=1: tex_x=4.
- Backpressure.
  - Stimulus: stream 8 requests with out_ready toggled 1,0,0,1,…
  - Response: no drops or duplicates, tags emitted in order, outputs stable while stalled, in_ready=0 once all 3 stages are full.
- Reset mid-stream.
  - Stimulus: 2 requests in flight, then reset asserted for 1 cycle.
  - Response: out_valid=0 and outputs zero the next cycle; no stale result afterwards. Extreme pa=0x8000 with dx=−130 yields a floored result without overflow.
